control_sequencer: RTL

//  Hardwired control unit driving the single-bus datapath: issues fetch/execute control strobes
//  (register out/in enables, Read, IncPC, ALU op one-hots) from an FSM stepping T0..T6 per instruction.

---
 rtl/control_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired T0..T6 fetch/execute sequencer for the single-bus datapath
// Optional CTRL_SINGLE_STEP_EN adds a Step input: every instruction boundary parks in IDLE until a Step rising edge.
module control_sequencer #(
  parameter int OP_MSB = 31,
  parameter int OP_W   = 5
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        MemReady,
  input  logic        Stop,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic        Step,
`endif
  output logic        PCout,
  output logic        Zhiout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Rout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        Rin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        Read,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic        SHR,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        MUL,
  output logic        DIV,
  output logic        NEG,
  output logic        NOT,
  output logic        Run,
  output logic        Illegal
);

  typedef enum logic [3:0] {
    RESET_ST, IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
  } state_t;

  localparam logic [OP_W-1:0] OPC_ADD  = OP_W'(5'b00011);
  localparam logic [OP_W-1:0] OPC_SUB  = OP_W'(5'b00100);
  localparam logic [OP_W-1:0] OPC_AND  = OP_W'(5'b00101);
  localparam logic [OP_W-1:0] OPC_OR   = OP_W'(5'b00110);
  localparam logic [OP_W-1:0] OPC_ROR  = OP_W'(5'b00111);
  localparam logic [OP_W-1:0] OPC_ROL  = OP_W'(5'b01000);
  localparam logic [OP_W-1:0] OPC_SHR  = OP_W'(5'b01001);
  localparam logic [OP_W-1:0] OPC_SHL  = OP_W'(5'b01010);
  localparam logic [OP_W-1:0] OPC_MUL  = OP_W'(5'b01111);
  localparam logic [OP_W-1:0] OPC_DIV  = OP_W'(5'b10000);
  localparam logic [OP_W-1:0] OPC_NEG  = OP_W'(5'b10001);
  localparam logic [OP_W-1:0] OPC_NOT  = OP_W'(5'b10010);
  localparam logic [OP_W-1:0] OPC_NOP  = OP_W'(5'b11010);
  localparam logic [OP_W-1:0] OPC_HALT = OP_W'(5'b11011);

  state_t          state, nxt;
  logic [OP_W-1:0] opcode, op_q, cur_op;
  logic            illegal_q;
  logic            c_alu3, c_md, c_un, c_nop, c_halt, op_ill;
  logic            alu_en;
  state_t          bnd;

`ifdef CTRL_SINGLE_STEP_EN
  logic step_q;
  logic unused_in;
  assign unused_in = ^{IR, Stop};
`else
  logic unused_in;
  assign unused_in = ^IR;
`endif

  assign opcode = IR[OP_MSB -: OP_W];
  // IR is decoded live in T3; later steps use the opcode captured at the end of T3
  assign cur_op = (state == T3) ? opcode : op_q;

  assign c_alu3 = cur_op inside {OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
                                 OPC_ROR, OPC_ROL, OPC_SHR, OPC_SHL};
  assign c_md   = cur_op inside {OPC_MUL, OPC_DIV};
  assign c_un   = cur_op inside {OPC_NEG, OPC_NOT};
  assign c_nop  = (cur_op == OPC_NOP);
  assign c_halt = (cur_op == OPC_HALT);
  assign op_ill = !(c_alu3 || c_md || c_un || c_nop || c_halt);

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state     <= RESET_ST;
      op_q      <= '0;
      illegal_q <= 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
      step_q    <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (state == T3) begin
        op_q <= opcode;
        if (op_ill) illegal_q <= 1'b1;
      end
`ifdef CTRL_SINGLE_STEP_EN
      step_q <= Step;
`endif
    end
  end

  always_comb begin
    nxt = state;
`ifdef CTRL_SINGLE_STEP_EN
    bnd = IDLE;
`else
    bnd = Stop ? IDLE : T0;
`endif
    case (state)
      RESET_ST: nxt = T0;
`ifdef CTRL_SINGLE_STEP_EN
      IDLE:     if (Step && !step_q) nxt = T0;
`else
      IDLE:     if (!Stop) nxt = T0;
`endif
      T0:       nxt = T1;
      T1:       if (MemReady) nxt = T2;
      T2:       nxt = T3;
      T3: begin
        if (c_alu3 || c_md || c_un) nxt = T4;
        else if (c_nop)             nxt = bnd;
        else                        nxt = HALT;
      end
      T4:       nxt = c_un ? bnd : T5;
      T5:       nxt = c_md ? T6 : bnd;
      T6:       nxt = bnd;
      HALT:     nxt = HALT;
      default:  nxt = RESET_ST;
    endcase
  end

  always_comb begin
    {PCout, Zhiout, Zlowout, MDRout, Rout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, Rin} = '0;
    {Gra, Grb, Grc, IncPC, Read} = '0;
    case (state)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      T1: begin Read = 1'b1; MDRin = 1'b1; end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3: begin
        if (c_alu3)    begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (c_md) begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (c_un) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
      end
      T4: begin
        if (c_un) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (c_alu3 || c_md) begin
          Rout = 1'b1; Zin = 1'b1; Grc = c_alu3; Grb = c_md;
        end
      end
      T5: begin
        if (c_alu3)    begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (c_md) begin Zlowout = 1'b1; LOin = 1'b1; end
      end
      T6: begin Zhiout = 1'b1; HIin = 1'b1; end
      default: ;
    endcase
  end

  assign alu_en = ((state == T3) && c_un) || ((state == T4) && (c_alu3 || c_md));
  assign ADD = alu_en && (cur_op == OPC_ADD);
  assign SUB = alu_en && (cur_op == OPC_SUB);
  assign AND = alu_en && (cur_op == OPC_AND);
  assign OR  = alu_en && (cur_op == OPC_OR);
  assign SHR = alu_en && (cur_op == OPC_SHR);
  assign SHL = alu_en && (cur_op == OPC_SHL);
  assign ROR = alu_en && (cur_op == OPC_ROR);
  assign ROL = alu_en && (cur_op == OPC_ROL);
  assign MUL = alu_en && (cur_op == OPC_MUL);
  assign DIV = alu_en && (cur_op == OPC_DIV);
  assign NEG = alu_en && (cur_op == OPC_NEG);
  assign NOT = alu_en && (cur_op == OPC_NOT);

  assign Run     = !(state inside {RESET_ST, IDLE, HALT});
  assign Illegal = illegal_q;

endmodule
